// File: rtl/uart_buffered.sv
// uart_buffered: buffered UART with TX/RX FIFOs, internal baud strobes and
// sticky error flags.
//
// Optional feature: define UART_PARITY_EN to send an even-parity bit after the
// data bits and check it on receive. Without it the parity states are skipped
// and parity_err is tied to 0.
//
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), DATA_BITS (5..9),
//             FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk_50m, rst      clock, asynchronous active-high reset
//   din, wr_en        host write into the TX FIFO
//   tx_full, tx_busy  TX FIFO full / TX path active
//   tx                serial out, idle high
//   rx                serial in, asynchronous
//   rd_en, dout       pop / first-word-fall-through head of the RX FIFO
//   rx_empty          RX FIFO empty
//   overrun, frame_err, parity_err  sticky errors, cleared by err_clr
//   err_clr           clears the sticky flags (a new error in the same cycle wins)

// Synchronous FIFO with wrap-bit pointers and a registered FWFT head.
module uart_buffered_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_nxt;
  logic [PW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // A full FIFO rejects a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head register tracks the next-cycle head; holds its value when empty.
  // If the next head is the slot being written now, bypass the write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (wr_nxt != rd_nxt) begin
      if (do_push && (rd_nxt == wr_ptr)) head <= wdata;
      else                               head <= mem[rd_nxt[AW-1:0]];
    end
  end
endmodule

module uart_buffered #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_empty,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 parity_err,
  input  logic                 err_clr
);
  localparam int unsigned TX_DIV = CLK_FREQ / BAUD;
  localparam int unsigned RX_DIV = CLK_FREQ / (16 * BAUD);
  localparam int unsigned TXCW   = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int unsigned RXCW   = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
  localparam int unsigned BCW    = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- strobes
  logic [TXCW-1:0] tx_div_cnt;
  logic [RXCW-1:0] rx_div_cnt;
  logic            tx_stb;
  logic            rx_stb;

  assign tx_stb = (tx_div_cnt == TXCW'(TX_DIV - 1));
  assign rx_stb = (rx_div_cnt == RXCW'(RX_DIV - 1));

  // Free-running baud dividers.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tx_div_cnt <= '0;
      rx_div_cnt <= '0;
    end else begin
      tx_div_cnt <= tx_stb ? '0 : tx_div_cnt + TXCW'(1);
      rx_div_cnt <= rx_stb ? '0 : rx_div_cnt + RXCW'(1);
    end
  end

  // ---------------------------------------------------------------- TX path
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_fifo_empty;
  logic                 tx_pop;

  uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (wr_en),
    .wdata (din),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_fifo_empty)
  );

  tx_state_t            tx_state, tx_state_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic [BCW-1:0]       tx_bit, tx_bit_n;
  logic                 tx_n;
  // Set once the start bit is on the line; START then waits one full bit.
  logic                 tx_armed, tx_armed_n;
`ifdef UART_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  assign tx_busy = (tx_state != TX_IDLE) || !tx_fifo_empty;

  // TX state and datapath registers; tx resets high so an aborted frame idles at once.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx       <= 1'b1;
      tx_armed <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_sh    <= tx_sh_n;
      tx_bit   <= tx_bit_n;
      tx       <= tx_n;
      tx_armed <= tx_armed_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state: each line value is registered on the strobe that starts its bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_sh_n    = tx_sh;
    tx_bit_n   = tx_bit;
    tx_n       = tx;
    tx_armed_n = tx_armed;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_head;
          tx_armed_n = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_n   = ^tx_head;
`endif
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_stb) begin
          if (!tx_armed) begin
            tx_n       = 1'b0;
            tx_armed_n = 1'b1;
          end else begin
            tx_n       = tx_sh[0];
            tx_sh_n    = tx_sh >> 1;
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tx_stb) begin
          if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_n       = tx_par;
            tx_state_n = TX_PARITY;
`else
            tx_n       = 1'b1;
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_n     = tx_sh[0];
            tx_sh_n  = tx_sh >> 1;
            tx_bit_n = tx_bit + BCW'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tx_stb) begin
          tx_n       = 1'b1;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        // Stop bit done: chain straight into the next start bit when data waits.
        if (tx_stb) begin
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sh_n    = tx_head;
            tx_n       = 1'b0;
            tx_armed_n = 1'b1;
`ifdef UART_PARITY_EN
            tx_par_n   = ^tx_head;
`endif
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  logic rx_meta;
  logic rx_sync;

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  rx_state_t            rx_state, rx_state_n;
  logic [3:0]           rx_scnt, rx_scnt_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic [BCW-1:0]       rx_bit, rx_bit_n;
  logic                 rx_push, rx_push_n;
  logic                 frame_set;
  logic                 rx_full;
`ifdef UART_PARITY_EN
  logic                 parity_set;
`endif

  uart_buffered_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk_50m),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_sh),
    .pop   (rd_en),
    .head  (dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // RX state and datapath registers.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_scnt  <= '0;
      rx_sh    <= '0;
      rx_bit   <= '0;
      rx_push  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_scnt  <= rx_scnt_n;
      rx_sh    <= rx_sh_n;
      rx_bit   <= rx_bit_n;
      rx_push  <= rx_push_n;
    end
  end

  // RX next state: START checks the 8th strobe after the falling edge, later
  // bits are sampled every 16 strobes so each sample lands mid-bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_scnt_n  = rx_scnt;
    rx_sh_n    = rx_sh;
    rx_bit_n   = rx_bit;
    rx_push_n  = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    parity_set = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_stb && !rx_sync) begin
          rx_scnt_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_stb) begin
          if (rx_scnt == 4'd7) begin
            rx_scnt_n  = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_scnt_n = rx_scnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (rx_stb) begin
          rx_scnt_n = rx_scnt + 4'd1;
          if (rx_scnt == 4'd15) begin
            rx_sh_n = {rx_sync, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state_n = RX_PARITY;
`else
              rx_state_n = RX_STOP;
`endif
            end else begin
              rx_bit_n = rx_bit + BCW'(1);
            end
          end
        end
      end
      RX_PARITY: begin
`ifdef UART_PARITY_EN
        if (rx_stb) begin
          rx_scnt_n = rx_scnt + 4'd1;
          if (rx_scnt == 4'd15) begin
            parity_set = (rx_sync != ^rx_sh);
            rx_state_n = RX_STOP;
          end
        end
`else
        rx_state_n = RX_IDLE;
`endif
      end
      RX_STOP: begin
        if (rx_stb) begin
          rx_scnt_n = rx_scnt + 4'd1;
          if (rx_scnt == 4'd15) begin
            if (rx_sync) rx_push_n = 1'b1;
            else         frame_set = 1'b1;
            rx_state_n = RX_IDLE;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- sticky errors
  // Set-dominant: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (rx_push && rx_full) || (overrun && !err_clr);
      frame_err <= frame_set || (frame_err && !err_clr);
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= parity_set || (parity_err && !err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered: reset, loopback, TX FIFO full, RX overrun,
// false start, framing error, optional parity and asynchronous reset mid-frame.
module tb_uart_buffered;
  localparam int unsigned CLK_FREQ   = 1600000;
  localparam int unsigned BAUD       = 100000;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BIT_CYC    = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned FL = 11;
`else
  localparam int unsigned FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr_en = 1'b0;
  logic       tx_full, tx_busy, tx;
  logic       rx_line;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       rx_empty, overrun, frame_err, parity_err;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign rx_line = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_buffered #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_50m    (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .tx_full    (tx_full),
    .tx_busy    (tx_busy),
    .tx         (tx),
    .rx         (rx_line),
    .rd_en      (rd_en),
    .dout       (dout),
    .rx_empty   (rx_empty),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits of one frame, index 0 = start bit.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9]   = ^d;
`endif
    return f;
  endfunction

  // Waits (bounded) for a start bit on tx, then samples every bit mid-period.
  task automatic capture(output logic [10:0] bits, output int start, output logic ok);
    bits  = '1;
    ok    = 1'b0;
    start = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok    = 1'b1;
        start = cyc;
      end
    end
    if (ok) begin
      repeat (BIT_CYC / 2) @(negedge clk);
      bits[0] = tx;
      for (int b = 1; b < FL; b++) begin
        repeat (BIT_CYC) @(negedge clk);
        bits[b] = tx;
      end
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int b = 0; b < FL; b++) begin
      rx_drv = f[b];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (rx_empty === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic pop_rx();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d);
    din   = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    logic        ok;
    int          st, prev_st;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_dout", dout, 0);
    check("rst_flags", {overrun, frame_err, parity_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte loopback
    loop_en = 1'b1;
    write_tx(8'hA5);
    check("lb_busy_n1", tx_busy, 1);
    check("lb_tx_idle_n1", tx, 1);
    capture(bits, st, ok);
    check("lb_start_seen", ok, 1);
    check("lb_frame", bits, exp_frame(8'hA5));
    wait_rx(ok);
    check("lb_rx_arrived", ok, 1);
    check("lb_dout", dout, 8'hA5);
    check("lb_no_err", {overrun, frame_err, parity_err}, 0);
    pop_rx();
    check("lb_rx_empty_after_pop", rx_empty, 1);
    check("lb_dout_hold", dout, 8'hA5);
    repeat (30) @(negedge clk);
    check("lb_busy_done", tx_busy, 0);

    // TX FIFO full: 0x06 is rejected, 0x01..0x05 go out back-to-back
    for (int k = 1; k <= 6; k++) begin
      din   = 8'(k);
      wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("full_after_writes", tx_full, 1);
    prev_st = 0;
    for (int k = 1; k <= 5; k++) begin
      capture(bits, st, ok);
      check($sformatf("full_frame%0d_seen", k), ok, 1);
      check($sformatf("full_frame%0d", k), bits, exp_frame(8'(k)));
      if (k >= 3) check($sformatf("full_gap%0d", k), st - prev_st, FL * BIT_CYC);
      prev_st = st;
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) ok = 1'b1;
    end
    check("full_no_sixth_frame", ok, 0);
    check("full_busy_done", tx_busy, 0);

    // RX overrun from the five looped frames
    check("ovr_flag", overrun, 1);
    check("ovr_frame_err", frame_err, 0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr_nonempty%0d", k), rx_empty, 0);
      check($sformatf("ovr_dout%0d", k), dout, 8'(k));
      pop_rx();
    end
    check("ovr_drained", rx_empty, 1);
    check("ovr_still_set", overrun, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_cleared", overrun, 0);
    loop_en = 1'b0;
    repeat (10) @(negedge clk);

    // False start glitch
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_push", rx_empty, 1);
    check("glitch_no_flag", {overrun, frame_err, parity_err}, 0);

    // Framing error: 0x3C with a low stop bit
    bits         = exp_frame(8'h3C);
    bits[FL - 1] = 1'b0;
    send_frame(bits);
    repeat (30) @(negedge clk);
    check("ferr_flag", frame_err, 1);
    check("ferr_no_push", rx_empty, 1);

    // Good injected frame
    send_frame(exp_frame(8'h5A));
    wait_rx(ok);
    check("rx5a_arrived", ok, 1);
    check("rx5a_dout", dout, 8'h5A);
    pop_rx();
    check("rx5a_popped", rx_empty, 1);

`ifdef UART_PARITY_EN
    // Parity generation and checking
    write_tx(8'h07);
    capture(bits, st, ok);
    check("par_tx_seen", ok, 1);
    check("par_tx_bit", bits[9], 1);
    check("par_tx_frame", bits, exp_frame(8'h07));
    check("par_clean", parity_err, 0);
    bits    = exp_frame(8'h07);
    bits[9] = 1'b0;
    send_frame(bits);
    wait_rx(ok);
    check("par_rx_arrived", ok, 1);
    check("par_err", parity_err, 1);
    check("par_dout", dout, 8'h07);
    pop_rx();
    repeat (10) @(negedge clk);
`endif

    // Leave a word in the RX FIFO and frame_err set, then reset mid-frame
    send_frame(exp_frame(8'hC3));
    wait_rx(ok);
    check("pre_rst_rx_word", ok, 1);
    write_tx(8'h55);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (tx === 1'b0) ok = 1'b1;
    end
    check("mid_rst_frame_started", ok, 1);
    repeat (20) @(negedge clk);
    check("mid_rst_busy_before", tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_rx_empty", rx_empty, 1);
    check("mid_rst_flags", {overrun, frame_err, parity_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("post_rst_tx_idle", tx, 1);
    check("post_rst_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
